// File: rtl/alu_result_buffer.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_buffer
// Purpose  : Two-entry elastic buffer behind the 8-bit ALU output stage.
//            Captures the dual-rail result pair (true + complement rail)
//            under a valid/ready handshake and checks that the rails are
//            exact complements. Derives zero/sign flags on capture and
//            presents one registered, flagged result per beat downstream.
//            A saturating counter tracks accepted entries that failed the
//            rail check.
// Ports    :
//   clk           in   1  system clock, rising edge
//   reset         in   1  asynchronous, active-high reset
//   in_valid      in   1  ALU presents a result this cycle
//   in_ready      out  1  buffer can accept a result (registered)
//   in_out        in   8  ALU true-rail result
//   in_not_out    in   8  ALU complement-rail result
//   out_valid     out  1  head entry valid (registered)
//   out_ready     in   1  consumer accepts head entry this cycle
//   out_data      out  8  head true-rail value
//   out_not_data  out  8  head complement-rail value, stored as received
//   out_zero      out  1  head out_data == 8'h00
//   out_sign      out  1  head out_data[7]
//   out_err       out  1  head entry failed the rail check
//   err_clear     in   1  synchronous clear of err_count
//   err_count     out  8  saturating count of errored accepted entries
// Revision : 1.0 - initial release
// ============================================================================
module alu_result_buffer (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_out,
    input  logic [7:0] in_not_out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic [7:0] out_not_data,
    output logic       out_zero,
    output logic       out_sign,
    output logic       out_err,
    input  logic       err_clear,
    output logic [7:0] err_count
);

    // Occupancy is the state: the number of stored entries.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic [7:0] ERR_MAX = 8'hFF;

    state_t     state;

    // Second (younger) entry; the head entry lives directly in the out_* regs
    // so every output is a flop with no mux behind it.
    logic [7:0] tail_data;
    logic [7:0] tail_not_data;
    logic       tail_zero;
    logic       tail_sign;
    logic       tail_err;

    logic       push;
    logic       pop;
    logic       in_zero;
    logic       in_sign;
    logic       in_err;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Flags come from the true rail only; the complement rail is only used
    // for the integrity check and is otherwise carried through untouched.
    assign in_zero = (in_out == 8'h00);
    assign in_sign = in_out[7];

    // Any bit position where both rails are 1, or where neither is 1,
    // means the pair is not a clean complement.
    assign in_err  = ((in_out & in_not_out) != 8'h00) |
                     ((in_out | in_not_out) != 8'hFF);

    // ------------------------------------------------------------------------
    // Occupancy FSM with registered handshake outputs and entry storage.
    // in_ready/out_valid are written together with every state change so
    // they always reflect the state being entered.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= EMPTY;
            in_ready      <= 1'b0;
            out_valid     <= 1'b0;
            out_data      <= 8'h00;
            out_not_data  <= 8'hFF;
            out_zero      <= 1'b1;
            out_sign      <= 1'b0;
            out_err       <= 1'b0;
            tail_data     <= 8'h00;
            tail_not_data <= 8'hFF;
            tail_zero     <= 1'b1;
            tail_sign     <= 1'b0;
            tail_err      <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    // in_ready is held low through reset; this raises it on
                    // the first edge afterwards. A push cannot occur before
                    // that edge because in_ready is still 0.
                    in_ready <= 1'b1;
                    if (push) begin
                        state        <= ONE;
                        out_valid    <= 1'b1;
                        out_data     <= in_out;
                        out_not_data <= in_not_out;
                        out_zero     <= in_zero;
                        out_sign     <= in_sign;
                        out_err      <= in_err;
                    end
                end

                ONE: begin
                    case ({push, pop})
                        2'b10: begin
                            // Head stays; new entry parks behind it.
                            state         <= TWO;
                            in_ready      <= 1'b0;
                            tail_data     <= in_out;
                            tail_not_data <= in_not_out;
                            tail_zero     <= in_zero;
                            tail_sign     <= in_sign;
                            tail_err      <= in_err;
                        end
                        2'b01: begin
                            // Head data is left in place; only valid drops.
                            state     <= EMPTY;
                            out_valid <= 1'b0;
                        end
                        2'b11: begin
                            // Head leaves and the incoming entry replaces it
                            // directly, sustaining one beat per cycle.
                            out_data     <= in_out;
                            out_not_data <= in_not_out;
                            out_zero     <= in_zero;
                            out_sign     <= in_sign;
                            out_err      <= in_err;
                        end
                        default: begin
                        end
                    endcase
                end

                TWO: begin
                    // in_ready is 0 here, so only a pop can happen.
                    if (pop) begin
                        state        <= ONE;
                        in_ready     <= 1'b1;
                        out_data     <= tail_data;
                        out_not_data <= tail_not_data;
                        out_zero     <= tail_zero;
                        out_sign     <= tail_sign;
                        out_err      <= tail_err;
                    end
                end

                default: begin
                    // Unreachable encoding: fall back to an empty buffer.
                    state     <= EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Rail-error counter. A clear in the same cycle as an errored push leaves
    // the count at 1 so that error is not lost.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count <= 8'h00;
        end else if (err_clear) begin
            err_count <= (push && in_err) ? 8'h01 : 8'h00;
        end else if (push && in_err && (err_count != ERR_MAX)) begin
            err_count <= err_count + 8'h01;
        end
    end

endmodule
`default_nettype wire

// File: doc/alu_result_buffer.md
# alu_result_buffer

Two-entry elastic buffer directly downstream of the 8-bit ALU output stage. It captures the dual-rail result pair (true rail and complement rail) with a valid/ready handshake and checks that the two rails are exact complements. It derives zero and sign flags and presents one registered, flagged result per beat to the writeback/bus stage. A saturating counter records rail-integrity errors.

## Interface
- No parameters; datapath fixed at 8 bits.
- clk  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  ALU stage presents a result this cycle
- in_ready  out  1  buffer can accept a result this cycle
- in_out  in  8  ALU true-rail result
- in_not_out  in  8  ALU complement-rail result
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer accepts head entry this cycle
- out_data  out  8  head entry true-rail value
- out_not_data  out  8  head entry complement-rail value, stored as received
- out_zero  out  1  head out_data == 8'h00
- out_sign  out  1  head out_data[7]
- out_err  out  1  head entry failed rail check
- err_clear  in  1  synchronous clear of err_count
- err_count  out  8  saturating count of accepted entries with rail errors

## Operation
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- Rail check on push: err = ((in_out & in_not_out) != 0) | ((in_out | in_not_out) != 8'hFF). This is equivalent to in_out != ~in_not_out. Errored entries are still stored and forwarded, with out_err=1. They are never dropped.
- Each entry stores data, not_data, zero, sign, and err. Flags are computed on push from in_out, never from in_not_out.
- FIFO order is strict. The head is always the oldest entry.
- State machine, with occupancy held as a state:
  - EMPTY: push → ONE.
  - ONE: push only → TWO; pop only → EMPTY; push and pop together → ONE, with the new entry becoming head on the next cycle.
  - TWO: pop → ONE; push is impossible because in_ready=0.
- in_ready is registered: 1 in EMPTY/ONE, 0 in TWO. It is also 0 while reset is asserted and on the first edge after reset.
- err_count:
  - +1 on each push with err=1.
  - Saturates at 8'hFF with no wrap.
  - err_clear alone → 0.
  - err_clear together with an errored push → 1.
- Outputs when out_valid=0: out_data, out_not_data, out_zero, out_sign and out_err hold their last values. Consumers ignore them.

## Timing
- Reset (async assert) immediately forces: state EMPTY, out_valid=0, in_ready=0, out_data=8'h00, out_not_data=8'hFF, out_zero=1, out_sign=0, out_err=0, err_count=0.
- After reset deasserts, in_ready rises at the first rising edge of clk.
- Latency: a push at edge N makes the entry visible with out_valid=1 after edge N. There is no combinational in→out path.
- Throughput: 1 beat/cycle sustained when out_ready is held high.
- Backpressure: with out_ready=0, two pushes fill the buffer. in_ready falls after the second push edge. The entry becomes full without losing the in-flight beat.
- in_valid while in_ready=0: no effect on state; inputs are ignored.
- Reset mid-operation: all entries are discarded and err_count is cleared. No partial beat is emitted.
- All outputs are registered. in_ready and out_valid depend only on state.

## Test plan
- Reset → out_valid=0, in_ready=0, err_count=0, out_zero=1, out_not_data=8'hFF. The first clk edge after deassert → in_ready=1.
- Push 8'h5A/8'hA5 then 8'h80/8'h7F with out_ready=1 → out_data=5A (zero=0, sign=0, err=0), then 80 (sign=1), each 1 cycle after push. err_count=0.
- Push 8'h00/8'hFF, then 8'h0F/8'h0F, with out_ready=0 → in_ready=0 after the second push. Then out_ready=1 pops 00 (zero=1, err=0) followed by 0F (err=1). err_count=1.
- Hold out_ready=1 and push 8'h01..8'h10 on consecutive cycles → the outputs appear in order with no bubbles and in_ready stays 1.
- Push 256 errored beats (e.g. 8'h33/8'h33) → err_count saturates at FF. err_clear together with another errored push → err_count=1.
- Assert reset while the buffer is in TWO → out_valid=0 and in_ready=0 immediately. After release, no stale entry appears.
